bus_sched: RTL and testbench

Sequencer and arbiter for the shared system bus (RAM plus I/O) on `clk_bus_i`, dividing each fixed-length bus frame into two windows:
- an SPI window, in which one queued host (Pi) read or write is performed;
- a CPU window, in which it generates the 6502 phi2 clock and RAM strobes.

It consumes the `cpu_ready_o` level from the host control register to stop the CPU clock between frames, and it is the only driver of the RAM strobes and the bus address/data mux select.

---
 rtl/bus_sched_pkg.sv | 23 ++
 rtl/bus_sched_if.sv | 35 +++
 rtl/bus_sched_frame_timer.sv | 39 +++
 rtl/bus_sched.sv | 180 ++++++++++++++++++
 tb/tb_bus_sched.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_sched_pkg.sv
// Shared types and default frame timing for the system bus scheduler.
package bus_pkg;

  localparam int DEF_FRAME_LEN  = 64;
  localparam int DEF_SPI_LEN    = 16;
  localparam int DEF_PHI2_START = 32;
  localparam int DEF_STROBE_LEN = 4;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] bus_addr_t;
  typedef logic [DATA_W-1:0] bus_data_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPI_SETUP  = 3'd1,
    SPI_STROBE = 3'd2,
    SPI_DONE   = 3'd3,
    CPU        = 3'd4
  } bus_state_t;

endpackage

// File: rtl/bus_sched_if.sv
// Host request, shared-bus and CPU/RAM control signals of the bus scheduler.
interface bus_sched_if;
  import bus_pkg::*;

  logic      spi_req_i;
  logic      spi_we_i;
  bus_addr_t spi_addr_i;
  bus_data_t spi_data_i;
  logic      spi_ack_o;
  bus_data_t spi_data_o;
  bus_addr_t spi_bus_addr_o;
  bus_data_t spi_bus_data_o;
  bus_data_t bus_data_i;
  logic      bus_spi_sel_o;
  logic      cpu_ready_i;
  logic      cpu_rw_i;
  logic      cpu_phi2_o;
  logic      ram_oe_no;
  logic      ram_we_no;

  modport master (
    output spi_req_i, spi_we_i, spi_addr_i, spi_data_i, bus_data_i,
    output cpu_ready_i, cpu_rw_i,
    input  spi_ack_o, spi_data_o, spi_bus_addr_o, spi_bus_data_o,
    input  bus_spi_sel_o, cpu_phi2_o, ram_oe_no, ram_we_no
  );

  modport slave (
    input  spi_req_i, spi_we_i, spi_addr_i, spi_data_i, bus_data_i,
    input  cpu_ready_i, cpu_rw_i,
    output spi_ack_o, spi_data_o, spi_bus_addr_o, spi_bus_data_o,
    output bus_spi_sel_o, cpu_phi2_o, ram_oe_no, ram_we_no
  );

endinterface

// File: rtl/bus_sched_frame_timer.sv
// Frame position counter for the bus scheduler, with decoded schedule points.
module frame_timer
  import bus_pkg::*;
#(
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int SPI_LEN    = DEF_SPI_LEN,
  parameter int PHI2_START = DEF_PHI2_START,
  parameter int CNT_W      = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_start,
  output logic             spi_end,
  output logic             phi2_start,
  output logic             frame_end
);

  logic [CNT_W-1:0] cnt_r;

  // Frame position, wrapping from FRAME_LEN-1 back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_W'(FRAME_LEN - 1)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign cnt         = cnt_r;
  assign frame_start = (cnt_r == '0);
  assign spi_end     = (cnt_r == CNT_W'(SPI_LEN));
  // Fires one count early: this is where cpu_ready is sampled so phi2 can rise on time.
  assign phi2_start  = (cnt_r == CNT_W'(PHI2_START - 1));
  assign frame_end   = (cnt_r == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/bus_sched.sv
// Shared-bus sequencer: one host access per frame in the SPI window, then the
// CPU window with phi2 and RAM strobes; sole driver of RAM strobes and mux select.
module bus_sched
  import bus_pkg::*;
#(
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int SPI_LEN    = DEF_SPI_LEN,
  parameter int PHI2_START = DEF_PHI2_START,
  parameter int STROBE_LEN = DEF_STROBE_LEN
) (
  input logic        clk_bus_i,
  input logic        res_ni,
  bus_sched_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int STB_W = $clog2(STROBE_LEN + 1);

  logic [CNT_W-1:0] cnt_s;
  logic             frame_start_s;
  logic             spi_end_s;
  logic             phi2_start_s;
  logic             frame_end_s;

  frame_timer #(
    .FRAME_LEN  (FRAME_LEN),
    .SPI_LEN    (SPI_LEN),
    .PHI2_START (PHI2_START),
    .CNT_W      (CNT_W)
  ) u_frame_timer (
    .clk         (clk_bus_i),
    .rst_n       (res_ni),
    .cnt         (cnt_s),
    .frame_start (frame_start_s),
    .spi_end     (spi_end_s),
    .phi2_start  (phi2_start_s),
    .frame_end   (frame_end_s)
  );

  bus_state_t       state_r,    state_s;
  logic [STB_W-1:0] stb_cnt_r,  stb_cnt_s;
  logic             req_we_r,   req_we_s;
  bus_addr_t        req_addr_r, req_addr_s;
  bus_data_t        req_data_r, req_data_s;
  bus_data_t        rd_data_r,  rd_data_s;
  logic             ready_r,    ready_s;
  logic             sel_r,      sel_s;
  logic             ack_r,      ack_s;
  logic             phi2_r,     phi2_s;
  logic             oe_n_r,     oe_n_s;
  logic             we_n_r,     we_n_s;
  logic             cpu_span_s;

  // Next-state and next-output decode from frame position and FSM state.
  always_comb begin
    state_s    = state_r;
    stb_cnt_s  = stb_cnt_r;
    req_we_s   = req_we_r;
    req_addr_s = req_addr_r;
    req_data_s = req_data_r;
    rd_data_s  = rd_data_r;
    sel_s      = sel_r;
    ack_s      = 1'b0;
    phi2_s     = 1'b0;
    oe_n_s     = 1'b1;
    we_n_s     = 1'b1;

    if (phi2_start_s) begin
      ready_s = bus.cpu_ready_i;
    end else begin
      ready_s = ready_r;
    end
    cpu_span_s = ready_r && (cnt_s >= CNT_W'(PHI2_START));

    case (state_r)
      IDLE: begin
        if (frame_start_s && bus.spi_req_i) begin
          req_we_s   = bus.spi_we_i;
          req_addr_s = bus.spi_addr_i;
          req_data_s = bus.spi_data_i;
          sel_s      = 1'b1;
          state_s    = SPI_SETUP;
        end else if (spi_end_s) begin
          state_s = CPU;
        end else begin
          state_s = IDLE;
        end
      end
      SPI_SETUP: begin
        state_s   = SPI_STROBE;
        stb_cnt_s = '0;
        oe_n_s    = req_we_r;
        we_n_s    = ~req_we_r;
      end
      SPI_STROBE: begin
        // Strobes are registered from the next state, so the last strobe cycle releases them.
        if (stb_cnt_r == STB_W'(STROBE_LEN - 1)) begin
          state_s = SPI_DONE;
          ack_s   = 1'b1;
          if (!req_we_r) begin
            rd_data_s = bus.bus_data_i;
          end else begin
            rd_data_s = rd_data_r;
          end
        end else begin
          stb_cnt_s = stb_cnt_r + STB_W'(1);
          oe_n_s    = req_we_r;
          we_n_s    = ~req_we_r;
        end
      end
      SPI_DONE: begin
        sel_s   = 1'b0;
        state_s = IDLE;
      end
      CPU: begin
        phi2_s = cpu_span_s;
        oe_n_s = ~(cpu_span_s & bus.cpu_rw_i);
        // WE releases on the final count so write data is held past phi2 fall.
        we_n_s = ~(cpu_span_s & ~bus.cpu_rw_i & ~frame_end_s);
        if (frame_end_s) begin
          state_s = IDLE;
        end else begin
          state_s = CPU;
        end
      end
      default: begin
        state_s = IDLE;
        sel_s   = 1'b0;
      end
    endcase
  end

  // FSM state, strobe counter, latched request and ready sample.
  always_ff @(posedge clk_bus_i or negedge res_ni) begin
    if (!res_ni) begin
      state_r    <= IDLE;
      stb_cnt_r  <= '0;
      req_we_r   <= 1'b0;
      req_addr_r <= '0;
      req_data_r <= '0;
      rd_data_r  <= '0;
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      stb_cnt_r  <= stb_cnt_s;
      req_we_r   <= req_we_s;
      req_addr_r <= req_addr_s;
      req_data_r <= req_data_s;
      rd_data_r  <= rd_data_s;
      ready_r    <= ready_s;
    end
  end

  // Output registers; strobes go inactive asynchronously on reset.
  always_ff @(posedge clk_bus_i or negedge res_ni) begin
    if (!res_ni) begin
      sel_r  <= 1'b0;
      ack_r  <= 1'b0;
      phi2_r <= 1'b0;
      oe_n_r <= 1'b1;
      we_n_r <= 1'b1;
    end else begin
      sel_r  <= sel_s;
      ack_r  <= ack_s;
      phi2_r <= phi2_s;
      oe_n_r <= oe_n_s;
      we_n_r <= we_n_s;
    end
  end

  assign bus.spi_ack_o      = ack_r;
  assign bus.spi_data_o     = rd_data_r;
  assign bus.spi_bus_addr_o = req_addr_r;
  assign bus.spi_bus_data_o = req_data_r;
  assign bus.bus_spi_sel_o  = sel_r;
  assign bus.cpu_phi2_o     = phi2_r;
  assign bus.ram_oe_no      = oe_n_r;
  assign bus.ram_we_no      = we_n_r;

endmodule

// File: tb/tb_bus_sched.sv
// Bench for bus_sched: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bus_sched;
  import bus_pkg::*;

  localparam int FL  = 64;
  localparam int SL  = 16;
  localparam int PS  = 32;
  localparam int STL = 4;

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   chk_on = 1'b0;

  bus_sched_if bif();

  bus_sched #(
    .FRAME_LEN  (FL),
    .SPI_LEN    (SL),
    .PHI2_START (PS),
    .STROBE_LEN (STL)
  ) dut (
    .clk_bus_i (clk),
    .res_ni    (res_n),
    .bus       (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: outputs after the clock edge at frame position mk.
  int        k_m = 0;
  int        k_last = -1;
  int        mk;
  bit        txn_on, txn_we, rdy_m, spi_lo, cpu_m;
  bus_addr_t lat_addr;
  bus_data_t lat_data, rd_m;
  logic      e_phi2, e_oe_n, e_we_n, e_sel, e_ack;

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      k_m = 0; k_last = -1; txn_on = 0; txn_we = 0; rdy_m = 0;
      lat_addr = '0; lat_data = '0; rd_m = '0;
      e_phi2 = 0; e_oe_n = 1; e_we_n = 1; e_sel = 0; e_ack = 0;
    end else begin
      mk = k_m;
      if (mk == 0) begin
        txn_on = bif.spi_req_i;
        if (txn_on) begin
          txn_we   = bif.spi_we_i;
          lat_addr = bif.spi_addr_i;
          lat_data = bif.spi_data_i;
        end
      end
      if (mk == PS - 1) rdy_m = bif.cpu_ready_i;
      spi_lo = txn_on && mk >= 1 && mk <= STL;
      cpu_m  = rdy_m && mk >= PS;
      e_sel  = txn_on && mk <= STL + 1;
      e_ack  = txn_on && mk == STL + 1;
      if (e_ack && !txn_we) rd_m = bif.bus_data_i;
      e_phi2 = cpu_m;
      e_oe_n = !((spi_lo && !txn_we) || (cpu_m && bif.cpu_rw_i));
      e_we_n = !((spi_lo && txn_we) || (cpu_m && !bif.cpu_rw_i && mk != FL - 1));
      k_last = mk;
      k_m    = (mk + 1) % FL;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("phi2",  bif.cpu_phi2_o,     e_phi2);
      chk("oe_n",  bif.ram_oe_no,      e_oe_n);
      chk("we_n",  bif.ram_we_no,      e_we_n);
      chk("sel",   bif.bus_spi_sel_o,  e_sel);
      chk("ack",   bif.spi_ack_o,      e_ack);
      chk("rdata", bif.spi_data_o,     rd_m);
      chk("baddr", bif.spi_bus_addr_o, lat_addr);
      chk("bdata", bif.spi_bus_data_o, lat_data);
    end
  end

  task automatic wait_k(input int n);
    bit hit = 0;
    for (int i = 0; i < 2 * FL && !hit; i++) begin
      @(negedge clk);
      if (k_m == n) hit = 1;
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL wait_k: position %0d never reached", n);
    end
  endtask

  task automatic host_txn(input bit we, input bus_addr_t a, input bus_data_t d,
                          output int ack_k, output logic [31:0] mask,
                          output bus_addr_t a_seen, output bus_data_t d_seen);
    bit done = 0;
    bif.spi_we_i = we; bif.spi_addr_i = a; bif.spi_data_i = d; bif.spi_req_i = 1'b1;
    ack_k = -1; mask = '0; a_seen = '0; d_seen = '0;
    for (int i = 0; i < 3 * FL && !done; i++) begin
      @(negedge clk);
      if (k_last >= 0 && k_last < SL && ((we && !bif.ram_we_no) || (!we && !bif.ram_oe_no)))
        mask[k_last] = 1'b1;
      if (k_last == 2) begin
        a_seen = bif.spi_bus_addr_o;
        d_seen = bif.spi_bus_data_o;
      end
      if (bif.spi_ack_o) begin
        ack_k = k_last;
        done  = 1;
      end
    end
    bif.spi_req_i = 1'b0;
  endtask

  int          ack_k, cnt_a, cnt_b;
  logic [31:0] mask;
  logic [63:0] wmask;
  bus_addr_t   a_seen;
  bus_data_t   d_seen;

  initial begin
    bif.spi_req_i = 0; bif.spi_we_i = 0; bif.spi_addr_i = '0; bif.spi_data_i = '0;
    bif.bus_data_i = 8'h3C; bif.cpu_ready_i = 1'b1; bif.cpu_rw_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_phi2", bif.cpu_phi2_o, 1'b0);
    chk("rst_oe_n", bif.ram_oe_no, 1'b1);
    chk("rst_we_n", bif.ram_we_no, 1'b1);
    chk("rst_sel",  bif.bus_spi_sel_o, 1'b0);
    chk("rst_ack",  bif.spi_ack_o, 1'b0);
    chk("rst_rd",   bif.spi_data_o, 8'h00);
    chk("rst_addr", bif.spi_bus_addr_o, 17'h0);
    chk("rst_wd",   bif.spi_bus_data_o, 8'h00);
    chk_on = 1'b1;
    res_n  = 1'b1;

    // Two idle frames with the CPU running, counting phi2 in the second.
    repeat (FL) @(negedge clk);
    cnt_a = 0;
    repeat (FL) begin
      @(negedge clk);
      if (bif.cpu_phi2_o) cnt_a++;
    end
    chk("idle_phi2_cnt", cnt_a, 32);

    wait_k(5);
    host_txn(1'b1, 17'h1F000, 8'hA5, ack_k, mask, a_seen, d_seen);
    chk("wr_ack_k", ack_k, 5);
    chk("wr_mask",  mask, 32'h0000_001E);
    chk("wr_addr",  a_seen, 17'h1F000);
    chk("wr_data",  d_seen, 8'hA5);

    bif.bus_data_i = 8'h3C;
    host_txn(1'b0, 17'h00123, 8'h00, ack_k, mask, a_seen, d_seen);
    chk("rd_ack_k", ack_k, 5);
    chk("rd_mask",  mask, 32'h0000_001E);
    chk("rd_data",  bif.spi_data_o, 8'h3C);

    wait_k(0);
    bif.cpu_rw_i = 1'b0;
    wmask = '0;
    repeat (FL) begin
      @(negedge clk);
      if (!bif.ram_we_no) wmask[k_last] = 1'b1;
    end
    bif.cpu_rw_i = 1'b1;
    chk("cpu_we_hi", wmask[63:32], 32'h7FFF_FFFF);
    chk("cpu_we_lo", wmask[31:0],  32'h0000_0000);

    wait_k(40);
    bif.cpu_ready_i = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < FL && k_last != FL - 1; i++) begin
      @(negedge clk);
      if (bif.cpu_phi2_o) cnt_a++;
    end
    chk("drop_phi2_cnt", cnt_a, 24);
    host_txn(1'b0, 17'h0ABCD, 8'h00, ack_k, mask, a_seen, d_seen);
    chk("stop_ack_k", ack_k, 5);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < FL && k_last != FL - 1; i++) begin
      @(negedge clk);
      if (bif.cpu_phi2_o) cnt_a++;
      if (!bif.ram_oe_no || !bif.ram_we_no) cnt_b++;
    end
    chk("stop_phi2_cnt", cnt_a, 0);
    chk("stop_strb_cnt", cnt_b, 0);
    bif.cpu_ready_i = 1'b1;

    wait_k(0);
    bif.spi_we_i = 1'b1; bif.spi_addr_i = 17'h0BEEF; bif.spi_data_i = 8'h5A; bif.spi_req_i = 1'b1;
    for (int i = 0; i < 8 && k_last != 2; i++) @(negedge clk);
    chk("pre_rst_we_n", bif.ram_we_no, 1'b0);
    #1 res_n = 1'b0;
    #1;
    chk("async_we_n", bif.ram_we_no, 1'b1);
    chk("async_oe_n", bif.ram_oe_no, 1'b1);
    chk("async_sel",  bif.bus_spi_sel_o, 1'b0);
    chk("async_addr", bif.spi_bus_addr_o, 17'h0);
    bif.spi_req_i = 1'b0;
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    cnt_a = 0;
    repeat (FL + 8) begin
      @(negedge clk);
      if (bif.spi_ack_o) cnt_a++;
    end
    chk("rst_no_ack", cnt_a, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bif.bus_data_i = 8'($urandom);
      bif.cpu_rw_i   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 2) bif.cpu_ready_i = ~bif.cpu_ready_i;
      if (bif.spi_req_i) begin
        if (bif.spi_ack_o && $urandom_range(0, 3) != 0) bif.spi_req_i = 1'b0;
        else if (e_sel == 1'b0 && k_last > STL + 1 && $urandom_range(0, 9) == 0 && !txn_pending())
          bif.spi_req_i = 1'b1;
      end else if ($urandom_range(0, 99) < 4) begin
        bif.spi_we_i   = 1'($urandom_range(0, 1));
        bif.spi_addr_i = 17'($urandom);
        bif.spi_data_i = 8'($urandom);
        bif.spi_req_i  = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic bit txn_pending();
    return 1'b0;
  endfunction

endmodule
